// File: rtl/cpu_defs_pkg.sv
// Shared CPU encodings: ALU control codes and multiply sequencer FSM states.
package cpu_defs;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_MULT = 4'b0011,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      MULT_IDLE = 2'b00,
      MULT_RUN  = 2'b01,
      MULT_DONE = 2'b10
   } mult_state_e;

endpackage

// File: rtl/mult_shift_add.sv
// Shift-add datapath: multiplicand/multiplier/accumulator with load, step and final negate.
// One partial product per step; prod is the combinational next accumulator value.
// No flow control of its own: the sequencer decides when to load and step.
module mult_shift_add #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic               negate,
   input  logic [WIDTH-1:0]   src1,
   input  logic [WIDTH-1:0]   src2,
   output logic               neg,
   output logic [2*WIDTH-1:0] prod
);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_add;
   logic [WIDTH:0]     mplier;
   logic [WIDTH:0]     ext1;
   logic [WIDTH:0]     ext2;
   logic [WIDTH:0]     mag1;
   logic [WIDTH:0]     mag2;

   // One extra bit so the most-negative operand has a representable magnitude.
   assign ext1 = {SIGNED && src1[WIDTH-1], src1};
   assign ext2 = {SIGNED && src2[WIDTH-1], src2};
   assign mag1 = ext1[WIDTH] ? -ext1 : ext1;
   assign mag2 = ext2[WIDTH] ? -ext2 : ext2;

   assign acc_add = mplier[0] ? (acc + mcand) : acc;
   assign prod    = negate ? -acc_add : acc_add;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         neg    <= 1'b0;
      end else if (load) begin
         mcand  <= {{(WIDTH-1){1'b0}}, mag1};
         mplier <= mag2;
         acc    <= '0;
         neg    <= SIGNED && (src1[WIDTH-1] ^ src2[WIDTH-1]);
      end else if (step) begin
         acc    <= prod;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: rtl/mult_seq_ctrl.sv
// EX-stage sequencer for mult: accepts on decode, runs WIDTH shift-add steps, pulses done.
// Latency: stall_o high from accept cycle T through T+WIDTH; done_o/result at T+WIDTH+1.
// Backpressure: stall_o holds the pipeline; flush_i aborts, other ALU codes never stall.
module mult_seq_ctrl
   import cpu_defs::*;
#(
   parameter int         WIDTH     = 32,
   parameter bit         SIGNED    = 1'b1,
   parameter logic [3:0] CTRL_MULT = ALU_MULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [3:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] result_hi_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   mult_state_e        state;
   logic [CNT_W-1:0]   cnt;
   logic               issue;
   logic               last;
   logic               load;
   logic               step;
   logic               negate;
   logic               neg;
   logic [2*WIDTH-1:0] prod;

   assign issue  = valid_i && (ALUCtrl_i == CTRL_MULT) && !flush_i;
   assign last   = (cnt == CNT_W'(WIDTH - 1));
   assign load   = (state == MULT_IDLE) && issue;
   assign step   = (state == MULT_RUN) && !flush_i;
   assign negate = step && last && neg;

   // Combinational in IDLE so the mult is held in EX from its very first cycle.
   assign stall_o = (state == MULT_RUN) || load;

   mult_shift_add #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
   ) u_engine (
      .clk    (clk_i),
      .rst_n  (rst_i),
      .load   (load),
      .step   (step),
      .negate (negate),
      .src1   (src1_i),
      .src2   (src2_i),
      .neg    (neg),
      .prod   (prod)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state       <= MULT_IDLE;
         cnt         <= '0;
         done_o      <= 1'b0;
         result_o    <= '0;
         result_hi_o <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            MULT_IDLE: begin
               cnt <= '0;
               if (issue) state <= MULT_RUN;
            end
            MULT_RUN: begin
               if (flush_i) begin
                  state <= MULT_IDLE;
                  cnt   <= '0;
               end else if (last) begin
                  state       <= MULT_DONE;
                  cnt         <= '0;
                  done_o      <= 1'b1;
                  result_o    <= prod[WIDTH-1:0];
                  result_hi_o <= prod[2*WIDTH-1:WIDTH];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            // The mult leaves EX this cycle, so decode inputs are not looked at here.
            MULT_DONE: state <= MULT_IDLE;
            default:   state <= MULT_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a queue-based scoreboard checked on done_o.
module tb_mult_seq_ctrl;
   import cpu_defs::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [3:0]  ALUCtrl_i = 4'b0000;
   logic [31:0] src1_i = '0;
   logic [31:0] src2_i = '0;
   logic        flush_i = 1'b0;
   logic        stall_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [31:0] result_hi_o;

   typedef struct {
      logic [63:0] prod;
      int          cyc;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic prev_done = 1'b0;

   mult_seq_ctrl dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ALUCtrl_i   (ALUCtrl_i),
      .src1_i      (src1_i),
      .src2_i      (src2_i),
      .flush_i     (flush_i),
      .stall_o     (stall_o),
      .done_o      (done_o),
      .result_o    (result_o),
      .result_hi_o (result_hi_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Presents a mult in the current cycle and returns that cycle; leaves EX empty after accept.
   task automatic start_mult(input logic [31:0] a, input logic [31:0] b, output int t);
      valid_i   = 1'b1;
      ALUCtrl_i = ALU_MULT;
      src1_i    = a;
      src2_i    = b;
      flush_i   = 1'b0;
      t         = cyc;
      #1 chk("stall_on_issue", stall_o, 1);
      tick();
      valid_i   = 1'b0;
      ALUCtrl_i = ALU_ADD;
   endtask

   task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
      int t;
      int bad;
      exp_t e;
      valid_i   = 1'b1;
      ALUCtrl_i = ALU_MULT;
      src1_i    = a;
      src2_i    = b;
      flush_i   = 1'b0;
      e.prod    = p;
      e.cyc     = cyc + 33;
      sbq.push_back(e);
      start_mult(a, b, t);
      bad = 0;
      for (int i = 1; i <= 32; i++) begin
         if (stall_o !== 1'b1) bad++;
         tick();
      end
      chk("stall_run_cycles_bad", bad, 0);
      chk("stall_low_at_done", stall_o, 0);
   endtask

   // Scoreboard monitor: every done_o must match the oldest expected product and cycle.
   always @(negedge clk_i) begin
      if (done_o === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", done_o, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("product", {result_hi_o, result_o}, e.prod);
            chk("done_cycle", cyc, e.cyc);
         end
      end
      if (prev_done === 1'b1) chk("done_consecutive", done_o, 0);
      prev_done = done_o;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its end, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int bad;
      logic [3:0] codes [5];
      exp_t e;
      codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};

      // Reset state
      tick(); tick(); tick();
      chk("rst_stall", stall_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_result_hi", result_hi_o, 0);
      rst_i = 1'b1;
      tick();

      // Basic products: positive, mixed sign, most-negative squared
      run_mult(32'd3, 32'd5, 64'h0000_0000_0000_000F);
      tick();
      run_mult(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
      tick();
      run_mult(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      tick();
      run_mult(32'd0, 32'd12345, 64'h0);
      tick();
      run_mult(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
      tick();

      // Non-mult ALU codes never stall nor complete
      valid_i = 1'b1;
      src1_i  = 32'd3;
      src2_i  = 32'd5;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         ALUCtrl_i = codes[i % 5];
         #1 if (stall_o !== 1'b0 || done_o !== 1'b0) bad++;
         tick();
      end
      chk("nonmult_stall_or_done_bad", bad, 0);
      valid_i   = 1'b0;
      ALUCtrl_i = ALU_ADD;
      tick();

      // Flush in IDLE beats a simultaneous mult
      valid_i   = 1'b1;
      ALUCtrl_i = ALU_MULT;
      flush_i   = 1'b1;
      #1 chk("flush_idle_stall", stall_o, 0);
      tick();
      valid_i   = 1'b0;
      flush_i   = 1'b0;
      ALUCtrl_i = ALU_ADD;
      #1 chk("flush_idle_not_accepted", stall_o, 0);
      tick();

      // Flush mid-run: abort, result kept, restart at T+12 finishes at T+45
      start_mult(32'd3, 32'd5, t);
      while (cyc < t + 10) tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_run_stall", stall_o, 0);
      chk("flush_keeps_result", {result_hi_o, result_o}, 64'hFFFF_FFFF_8000_0000);
      tick();
      chk("restart_cycle_is_t12", cyc, t + 12);
      run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      tick();

      // Reset mid-run abandons the operation
      start_mult(32'd100, 32'd200, t);
      while (cyc < t + 20) tick();
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      chk("midrst_stall", stall_o, 0);
      chk("midrst_done", done_o, 0);
      chk("midrst_result", result_o, 0);
      chk("midrst_result_hi", result_hi_o, 0);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (stall_o !== 1'b0) bad++;
         tick();
      end
      chk("midrst_quiet_bad", bad, 0);

      // Back-to-back: decode/flush during DONE are ignored, next mult issues right after
      valid_i   = 1'b1;
      ALUCtrl_i = ALU_MULT;
      src1_i    = 32'd9;
      src2_i    = 32'd11;
      e.prod    = 64'd99;
      e.cyc     = cyc + 33;
      sbq.push_back(e);
      start_mult(32'd9, 32'd11, t);
      while (cyc < t + 33) tick();
      valid_i   = 1'b1;
      ALUCtrl_i = ALU_MULT;
      src1_i    = 32'hFFFF_FFFE;
      src2_i    = 32'h7FFF_FFFF;
      flush_i   = 1'b1;
      #1 chk("done_cycle_stall", stall_o, 0);
      tick();
      run_mult(32'hFFFF_FFFE, 32'h7FFF_FFFF, 64'hFFFF_FFFF_0000_0002);
      tick();
      tick();
      tick();

      chk("scoreboard_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Multi-cycle sequencer for the `mult` operation (ALU control code 4'b0011) in the single-issue CPU's EX stage.
- Accepts a multiply when the ALU control decode selects mult and EX is valid.
- Stalls the pipeline while an iterative shift-add engine runs for WIDTH cycles, then presents the 2*WIDTH product for one cycle.
- All other ALU operations pass through with no stall.

Parameters:
WIDTH, 32, operand width in bits
SIGNED, 1, 1 = two's-complement multiply (MIPS mult), 0 = unsigned
CTRL_MULT, 4'b0011, ALU control code that triggers the sequencer

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, synchronous, active-low
valid_i  input  1  EX stage holds a valid instruction
ALUCtrl_i  input  4  ALU control code from the ALU control decoder
src1_i  input  WIDTH  multiplicand (rs)
src2_i  input  WIDTH  multiplier (rt)
flush_i  input  1  squash the EX instruction (branch/jump redirect)
stall_o  output  1  hold PC and IF/ID/ID-EX registers
done_o  output  1  one-cycle pulse: product valid, write back this cycle
result_o  output  WIDTH  product bits [WIDTH-1:0]
result_hi_o  output  WIDTH  product bits [2*WIDTH-1:WIDTH]

Behaviour:
- Reset: on a clock edge with rst_i==0, all state clears.
  - state=IDLE, counter=0, accumulator=0.
  - stall_o=0, done_o=0, result_o=0, result_hi_o=0.
  - Reset applied mid-RUN abandons the operation; no done_o follows.
- issue = valid_i && (ALUCtrl_i==CTRL_MULT) && !flush_i.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - With issue at edge T, latch the operands and go to RUN.
  - When SIGNED=1, latch operand magnitudes plus neg = src1_i[MSB]^src2_i[MSB].
  - stall_o = issue (combinational), so the mult instruction is held from cycle T.
  - Without issue, stay in IDLE with stall_o=0.
- RUN: WIDTH iterations, counter 0..WIDTH-1.
  - Each cycle: if multiplier[0]==1, acc += multiplicand (2*WIDTH wide, no overflow possible).
  - Then multiplicand <<= 1 and multiplier >>= 1.
  - stall_o=1 throughout.
  - When counter==WIDTH-1, go to DONE. On entry to DONE, apply the two's-complement negate of acc if neg && SIGNED.
- DONE:
  - Registered done_o=1; result_o/result_hi_o updated with the final product; stall_o=0.
  - Next state is IDLE unconditionally. valid_i/ALUCtrl_i are ignored in DONE, because the same mult instruction leaves EX this cycle.
- Latency: accept at T; stall_o high for cycles T..T+WIDTH (WIDTH+1 cycles); done_o at T+WIDTH+1.
- result_o/result_hi_o hold their last value until the next completion; they are not cleared by flush.
- flush_i:
  - In IDLE, flush wins over a simultaneous mult; nothing is accepted and stall_o=0.
  - In RUN, abort to IDLE next edge; no done_o; result registers unchanged.
  - In DONE, no effect; the result has already been delivered.
- Non-mult codes (0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt): never stall and never pulse done_o.
- Boundary cases:
  - Operand 0 still takes the full WIDTH cycles; there is no early exit.
  - Most-negative operands are handled by magnitude in WIDTH+1 bits. 0x80000000*0x80000000 = 2^62.
- done_o is never asserted in two consecutive cycles.

Decomposition:
- Shared package (cpu_defs): ALU control encodings (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_MULT=0011, ALU_SUB=0110, ALU_SLT=0111) and MULT FSM state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
- One sub-module, mult_shift_add, holds the multiplicand/multiplier/accumulator registers with load, step and negate controls.
- mult_seq_ctrl holds the FSM, counter, stall/done logic and result registers.

Test Plan:
- Unsigned-positive case: issue ALUCtrl_i=0011, src1=3, src2=5 at T -> stall_o=1 for T..T+32, done_o=1 at T+33, result_o=15, result_hi_o=0.
- Signed case: src1=-7 (0xFFFFFFF9), src2=6 -> result_o=0xFFFFFFD6, result_hi_o=0xFFFFFFFF.
- Corner case: src1=src2=0x80000000 -> result_hi_o=0x40000000, result_o=0x00000000.
- Non-mult code: ALUCtrl_i=0010 with valid_i=1 for 10 cycles -> stall_o=0 and done_o=0 throughout.
- Flush mid-run: issue 3*5, then flush_i=1 at T+10 -> stall_o=0 from T+11, no done_o, result_o keeps its previous value. A new issue at T+12 completes with done_o at T+45.
- Reset mid-run: rst_i=0 at T+20 for one edge -> stall_o=0, done_o=0, result_o=0, result_hi_o=0 afterwards. Back-to-back mults (issue again in the cycle after DONE) -> each completes in WIDTH+1 stall cycles.
